// File: rtl/alu_pkg.sv
// Opcode encodings and legality check shared by the ALU core and the
// upstream decoder.
package alu_pkg;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_ADDU = 5'b00001;
    localparam logic [4:0] ALU_SUB  = 5'b00010;
    localparam logic [4:0] ALU_SUBU = 5'b00011;
    localparam logic [4:0] ALU_INC  = 5'b00100;
    localparam logic [4:0] ALU_DEC  = 5'b00101;
    localparam logic [4:0] ALU_AND  = 5'b01000;
    localparam logic [4:0] ALU_OR   = 5'b01001;
    localparam logic [4:0] ALU_XOR  = 5'b01010;
    localparam logic [4:0] ALU_NOT  = 5'b01100;
    localparam logic [4:0] ALU_SLL  = 5'b10000;
    localparam logic [4:0] ALU_SRL  = 5'b10001;
    localparam logic [4:0] ALU_SLA  = 5'b10010;
    localparam logic [4:0] ALU_SRA  = 5'b10011;
    localparam logic [4:0] ALU_LE   = 5'b11000;
    localparam logic [4:0] ALU_LT   = 5'b11001;
    localparam logic [4:0] ALU_GE   = 5'b11010;
    localparam logic [4:0] ALU_GT   = 5'b11011;
    localparam logic [4:0] ALU_EQ   = 5'b11100;
    localparam logic [4:0] ALU_NE   = 5'b11101;

    function automatic logic is_legal_op(input logic [4:0] op);
        case (op)
            ALU_ADD, ALU_ADDU, ALU_SUB, ALU_SUBU, ALU_INC, ALU_DEC,
            ALU_AND, ALU_OR, ALU_XOR, ALU_NOT,
            ALU_SLL, ALU_SRL, ALU_SLA, ALU_SRA,
            ALU_LE, ALU_LT, ALU_GE, ALU_GT, ALU_EQ, ALU_NE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational op evaluator: result plus overflow, carry and illegal flags.
// Arithmetic runs at WIDTH+1 bits so the top bit is the carry/no-borrow.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       op,
    output logic [WIDTH-1:0] c,
    output logic             ovf,
    output logic             carry,
    output logic             illegal
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH:0]          sum;
    logic [WIDTH:0]          diff;
    logic [WIDTH:0]          incr;
    logic [WIDTH:0]          decr;
    logic signed [WIDTH-1:0] a_s;
    logic [SHW-1:0]          sh;
    logic                    sum_ovf;
    logic                    diff_ovf;
    logic                    lt;
    logic                    eq;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign incr = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
    assign decr = {1'b0, a} + {1'b0, {WIDTH{1'b1}}};
    assign a_s  = a;
    assign sh   = b[SHW-1:0];

    assign sum_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign diff_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    // Signed less-than from the subtractor: sign of a-b corrected by its overflow.
    assign lt = diff[WIDTH-1] ^ diff_ovf;
    assign eq = (a == b);

    always_comb begin
        c       = '0;
        ovf     = 1'b0;
        carry   = 1'b0;
        illegal = !is_legal_op(op);
        case (op)
            ALU_ADD:  begin c = sum[WIDTH-1:0];  ovf = sum_ovf;  carry = sum[WIDTH];  end
            ALU_ADDU: begin c = sum[WIDTH-1:0];  carry = sum[WIDTH];                  end
            ALU_SUB:  begin c = diff[WIDTH-1:0]; ovf = diff_ovf; carry = diff[WIDTH]; end
            ALU_SUBU: begin c = diff[WIDTH-1:0]; carry = diff[WIDTH];                 end
            ALU_INC:  begin
                c     = incr[WIDTH-1:0];
                ovf   = (a == {1'b0, {(WIDTH-1){1'b1}}});
                carry = incr[WIDTH];
            end
            ALU_DEC:  begin
                c     = decr[WIDTH-1:0];
                ovf   = (a == {1'b1, {(WIDTH-1){1'b0}}});
                carry = decr[WIDTH];
            end
            ALU_AND:  c = a & b;
            ALU_OR:   c = a | b;
            ALU_XOR:  c = a ^ b;
            ALU_NOT:  c = ~a;
            ALU_SLL,
            ALU_SLA:  c = a << sh;
            ALU_SRL:  c = a >> sh;
            ALU_SRA:  c = a_s >>> sh;
            ALU_LE:   begin c = {{(WIDTH-1){1'b0}}, lt | eq};   carry = diff[WIDTH]; end
            ALU_LT:   begin c = {{(WIDTH-1){1'b0}}, lt};        carry = diff[WIDTH]; end
            ALU_GE:   begin c = {{(WIDTH-1){1'b0}}, !lt};       carry = diff[WIDTH]; end
            ALU_GT:   begin c = {{(WIDTH-1){1'b0}}, !(lt | eq)}; carry = diff[WIDTH]; end
            ALU_EQ:   begin c = {{(WIDTH-1){1'b0}}, eq};        carry = diff[WIDTH]; end
            ALU_NE:   begin c = {{(WIDTH-1){1'b0}}, !eq};       carry = diff[WIDTH]; end
            default:  c = '0;
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides and a sticky
// signed-overflow status bit.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       alu_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             overflow,
    output logic             carry,
    output logic             zero,
    output logic             illegal,
    output logic             ovf_sticky,
    input  logic             ovf_clr
);

    logic             vld_p1;
    logic [WIDTH-1:0] a_p1;
    logic [WIDTH-1:0] b_p1;
    logic [4:0]       op_p1;
    logic [WIDTH-1:0] c_core;
    logic             ovf_core;
    logic             carry_core;
    logic             ill_core;
    logic             adv1;
    logic             adv2;

    assign adv2 = !out_valid || out_ready;
    assign adv1 = !vld_p1 || adv2;
    // Gated by rst_n so the upstream stage sees no room while held in reset.
    assign in_ready = rst_n && adv1;

    // Stage 1: operand/op capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            a_p1   <= '0;
            b_p1   <= '0;
            op_p1  <= '0;
        end else if (adv1) begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                a_p1  <= a;
                b_p1  <= b;
                op_p1 <= alu_code;
            end
        end
    end

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a       (a_p1),
        .b       (b_p1),
        .op      (op_p1),
        .c       (c_core),
        .ovf     (ovf_core),
        .carry   (carry_core),
        .illegal (ill_core)
    );

    // Stage 2: result and flags, held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            c         <= '0;
            overflow  <= 1'b0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
        end else if (adv2) begin
            out_valid <= vld_p1;
            if (vld_p1) begin
                c        <= c_core;
                overflow <= ovf_core;
                carry    <= carry_core;
                zero     <= (c_core == '0);
                illegal  <= ill_core;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_sticky <= 1'b0;
        else if (out_valid && out_ready && overflow)
            ovf_sticky <= 1'b1;
        else if (ovf_clr)
            ovf_sticky <= 1'b0;
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: 16-bit instance for ops, handshake and reset,
// plus an 8-bit instance for width-dependent flags.
module tb_alu_pipe;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a, b, c;
    logic [4:0]  alu_code;
    logic        overflow, carry, zero, illegal, ovf_sticky, ovf_clr;

    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0]  a8, b8, c8;
    logic [4:0]  alu_code8;
    logic        overflow8, carry8, zero8, illegal8, ovf_sticky8, ovf_clr8;

    int checks = 0;
    int errors = 0;

    alu_pipe #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .alu_code(alu_code), .out_valid(out_valid), .out_ready(out_ready),
        .c(c), .overflow(overflow), .carry(carry), .zero(zero), .illegal(illegal),
        .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
    );

    alu_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .alu_code(alu_code8), .out_valid(out_valid8), .out_ready(out_ready8),
        .c(c8), .overflow(overflow8), .carry(carry8), .zero(zero8), .illegal(illegal8),
        .ovf_sticky(ovf_sticky8), .ovf_clr(ovf_clr8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 with the result on the outputs.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [15:0] av,
                          input logic [15:0] bv, input logic [15:0] exp_c,
                          input logic exp_ovf, input logic exp_carry, input logic exp_ill);
        alu_code = op;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        check({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_lat1_valid"}, out_valid, 0);
        @(posedge clk); #1;
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_c"}, c, exp_c);
        check({tag, "_ovf"}, overflow, exp_ovf);
        check({tag, "_carry"}, carry, exp_carry);
        check({tag, "_illegal"}, illegal, exp_ill);
        check({tag, "_zero"}, zero, (exp_c == 16'h0000));
    endtask

    logic [4:0]  bt_op [4];
    logic [15:0] bt_a  [4];
    logic [15:0] bt_b  [4];
    logic [15:0] bt_c  [4];
    int          sent, rcv;
    logic        acc;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
        a = '0; b = '0; alu_code = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b1; ovf_clr8 = 1'b0;
        a8 = '0; b8 = '0; alu_code8 = '0;

        bt_op[0] = ALU_ADD; bt_a[0] = 16'h0001; bt_b[0] = 16'h0002; bt_c[0] = 16'h0003;
        bt_op[1] = ALU_SUB; bt_a[1] = 16'h000A; bt_b[1] = 16'h0003; bt_c[1] = 16'h0007;
        bt_op[2] = ALU_XOR; bt_a[2] = 16'hFF00; bt_b[2] = 16'h0FF0; bt_c[2] = 16'hF0F0;
        bt_op[3] = ALU_OR;  bt_a[3] = 16'h1200; bt_b[3] = 16'h0034; bt_c[3] = 16'h1234;

        #2;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_c", c, 0);
        check("rst_flags", {overflow, carry, zero, illegal}, 0);
        check("rst_sticky", ovf_sticky, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Signed overflow and sticky set one cycle after the transfer
        run_op("add_ovf", ALU_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1, 0, 0);
        check("sticky_before_xfer", ovf_sticky, 0);
        @(posedge clk); #1;
        check("sticky_after_xfer", ovf_sticky, 1);

        run_op("lt",   ALU_LT,   16'h8000, 16'h0001, 16'h0001, 0, 1, 0);
        run_op("gt",   ALU_GT,   16'h0005, 16'h0005, 16'h0000, 0, 1, 0);
        run_op("le",   ALU_LE,   16'h0005, 16'h0005, 16'h0001, 0, 1, 0);
        run_op("ge",   ALU_GE,   16'hFFFF, 16'h0001, 16'h0000, 0, 1, 0);
        run_op("eq",   ALU_EQ,   16'h1234, 16'h1234, 16'h0001, 0, 1, 0);
        run_op("ne",   ALU_NE,   16'h1234, 16'h1234, 16'h0000, 0, 1, 0);
        run_op("sra",  ALU_SRA,  16'h8001, 16'h0004, 16'hF800, 0, 0, 0);
        run_op("sll",  ALU_SLL,  16'h0001, 16'h0011, 16'h0002, 0, 0, 0);
        run_op("srl",  ALU_SRL,  16'h8000, 16'h000F, 16'h0001, 0, 0, 0);
        run_op("sla",  ALU_SLA,  16'h0003, 16'h0002, 16'h000C, 0, 0, 0);
        run_op("addu", ALU_ADDU, 16'hFFFF, 16'h0001, 16'h0000, 0, 1, 0);
        run_op("sub",  ALU_SUB,  16'h8000, 16'h0001, 16'h7FFF, 1, 1, 0);
        run_op("subu", ALU_SUBU, 16'h0003, 16'h0005, 16'hFFFE, 0, 0, 0);
        run_op("inc",  ALU_INC,  16'hFFFF, 16'h0000, 16'h0000, 0, 1, 0);
        run_op("dec",  ALU_DEC,  16'h8000, 16'h0000, 16'h7FFF, 1, 1, 0);
        run_op("and",  ALU_AND,  16'hF0F0, 16'h3C3C, 16'h3030, 0, 0, 0);
        run_op("not",  ALU_NOT,  16'h00FF, 16'h0000, 16'hFF00, 0, 0, 0);
        run_op("ill6", 5'b00110, 16'h1234, 16'h5678, 16'h0000, 0, 0, 1);
        run_op("ill31", 5'b11111, 16'hFFFF, 16'hFFFF, 16'h0000, 0, 0, 1);
        @(posedge clk); #1;

        // Sticky clear alone, then clear colliding with a setting transfer
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        check("sticky_cleared", ovf_sticky, 0);
        run_op("add_ovf2", ALU_ADD, 16'h4000, 16'h4000, 16'h8000, 1, 0, 0);
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        check("sticky_set_wins", ovf_sticky, 1);

        // Backpressure: four beats with the consumer stalled
        out_ready = 1'b0;
        sent = 0;
        rcv  = 0;
        alu_code = bt_op[0]; a = bt_a[0]; b = bt_b[0]; in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                alu_code = bt_op[sent]; a = bt_a[sent]; b = bt_b[sent];
            end
        end
        check("bp_accepted", sent, 2);
        @(negedge clk);
        check("bp_in_ready_low", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_c_first", c, bt_c[0]);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("bp_held_valid", out_valid, 1);
        check("bp_held_c", c, bt_c[0]);
        check("bp_held_ready", in_ready, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && rcv < 4; cyc++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            if (out_valid) begin
                check($sformatf("bp_out%0d", rcv), c, bt_c[rcv]);
                rcv++;
            end
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                if (sent < 4) begin
                    alu_code = bt_op[sent]; a = bt_a[sent]; b = bt_b[sent];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check("bp_received", rcv, 4);
        check("bp_sent", sent, 4);
        @(negedge clk);
        check("bp_no_dup", out_valid, 0);
        @(posedge clk); #1;

        // Reset with both stages full
        out_ready = 1'b0;
        alu_code = ALU_ADD; a = 16'h0001; b = 16'h0001; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 16'h0002; b = 16'h0002;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("full_out_valid", out_valid, 1);
        check("full_in_ready", in_ready, 0);
        check("full_sticky", ovf_sticky, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_c", c, 0);
        check("midrst_sticky", ovf_sticky, 0);
        check("midrst_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        run_op("post_rst", ALU_ADD, 16'h0010, 16'h0020, 16'h0030, 0, 0, 0);
        @(posedge clk); #1;

        // 8-bit instance: inc into overflow, then unsigned borrow
        check("w8_in_ready", in_ready8, 1);
        alu_code8 = ALU_INC; a8 = 8'h7F; b8 = 8'h00; in_valid8 = 1'b1;
        @(posedge clk); #1;
        alu_code8 = ALU_SUBU; a8 = 8'h00; b8 = 8'h01;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        check("w8_inc_valid", out_valid8, 1);
        check("w8_inc_c", c8, 8'h80);
        check("w8_inc_ovf", overflow8, 1);
        check("w8_inc_zero", zero8, 0);
        @(posedge clk); #1;
        check("w8_subu_valid", out_valid8, 1);
        check("w8_subu_c", c8, 8'hFF);
        check("w8_subu_carry", carry8, 0);
        check("w8_subu_ovf", overflow8, 0);
        check("w8_subu_illegal", illegal8, 0);
        check("w8_sticky", ovf_sticky8, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
